coin_acceptor: RTL and testbench

Front-end stage of the cola vending machine. It conditions the two raw coin-chute sensors (nickel, dime), debounces them, and queues accepted coins in a 4-entry FIFO. It presents the coins to the vend FSM as single-cycle 2-bit codes on `coin`: 01 = 5c, 10 = 10c, 00 = none, 11 never driven. It holds coins back while the vend FSM is dispensing (`coke` high), because the FSM discards any coin it receives in that state.

---
 rtl/coin_acceptor_if.sv | 20 ++
 rtl/coin_acceptor.sv | 152 +++++++++++++++
 tb/tb_coin_acceptor.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_acceptor_if.sv
// Coin-chute bus: raw sensors and the dispense flag toward the acceptor, queued coin codes and status back.
// master = vend side / stimulus, slave = coin_acceptor.
interface coin_acceptor_if;
  logic       nickel_in;
  logic       dime_in;
  logic       coke;
  logic [1:0] coin;
  logic       reject;
  logic [2:0] pending;

  modport master (
    output nickel_in, dime_in, coke,
    input  coin, reject, pending
  );

  modport slave (
    input  nickel_in, dime_in, coke,
    output coin, reject, pending
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin front end: sync + debounce two chute sensors, queue coins in a 4-deep FIFO, issue one-cycle codes.
// Push DEB_CYCLES+2 edges after first sample; pops stall while coke is high and always leave a 00 gap.
module coin_acceptor #(
  parameter int DEB_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  coin_acceptor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} deb_state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

  // Channel index 0 = nickel, 1 = dime throughout.
  logic [1:0] sync1;
  logic [1:0] sync2;
  deb_state_t state [2];
  logic [7:0] cnt   [2];
  logic [1:0] req;

  logic [1:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic [1:0] coin_q;
  logic       reject_q;

  logic       full;
  logic       empty;
  logic       pop;
  logic       push;
  logic       drop;
  logic [1:0] push_code;

  always_comb begin
    req = 2'b00;
    for (int c = 0; c < 2; c++) begin
      req[c] = (state[c] == CONFIRM) && sync2[c] && (cnt[c] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
      for (int c = 0; c < 2; c++) begin
        state[c] <= IDLE;
        cnt[c]   <= 8'd0;
      end
    end else begin
      sync1 <= {bus.dime_in, bus.nickel_in};
      sync2 <= sync1;
      for (int c = 0; c < 2; c++) begin
        case (state[c])
          IDLE: begin
            if (sync2[c]) begin
              state[c] <= CONFIRM;
              cnt[c]   <= 8'd1;
            end
          end
          CONFIRM: begin
            if (!sync2[c]) begin
              state[c] <= IDLE;
            end else if (cnt[c] == CNT_LAST) begin
              state[c] <= HELD;
            end else begin
              cnt[c] <= cnt[c] + 8'd1;
            end
          end
          HELD: begin
            if (!sync2[c]) begin
              state[c] <= RELEASE;
              cnt[c]   <= 8'd1;
            end
          end
          RELEASE: begin
            // A return to high here is contact bounce, not a second coin.
            if (sync2[c]) begin
              state[c] <= HELD;
            end else if (cnt[c] == CNT_LAST) begin
              state[c] <= IDLE;
            end else begin
              cnt[c] <= cnt[c] + 8'd1;
            end
          end
          default: state[c] <= IDLE;
        endcase
      end
    end
  end

  assign full  = (count == 3'd4);
  assign empty = (count == 3'd0);
  // Requiring coin==00 forces a gap cycle, so a coke rise is always seen before the next pop.
  assign pop   = !empty && !bus.coke && (coin_q == 2'b00);

  always_comb begin
    push      = 1'b0;
    drop      = 1'b0;
    push_code = 2'b00;
    case (req)
      2'b01: begin
        push_code = 2'b01;
        push      = !full || pop;
        drop      = full && !pop;
      end
      2'b10: begin
        push_code = 2'b10;
        push      = !full || pop;
        drop      = full && !pop;
      end
      2'b11:   drop = 1'b1;
      default: drop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_code;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      coin_q   <= 2'b00;
      reject_q <= 1'b0;
    end else begin
      reject_q <= drop;
      coin_q   <= pop ? mem[rd_ptr] : 2'b00;
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (push && !pop) begin
        count <= count + 3'd1;
      end else if (pop && !push) begin
        count <= count - 3'd1;
      end
    end
  end

  assign bus.coin    = coin_q;
  assign bus.reject  = reject_q;
  assign bus.pending = count;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: vector table, directed corner sequences, and random stimulus against a run-length model.
module tb_coin_acceptor;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  coin_acceptor_if bus ();

  coin_acceptor #(.DEB_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit model_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a coin is accepted after DEB consecutive high synchronized samples
  // while armed; the channel re-arms after DEB consecutive low samples.
  bit         raw1 [2];
  bit         raw2 [2];
  bit         s_now [2];
  bit         req_m [2];
  int         hi_run [2];
  int         lo_run [2];
  bit         armed [2] = '{1'b1, 1'b1};
  logic [1:0] m_q [$];
  logic [1:0] m_coin = 2'b00;
  bit         m_rej = 1'b0;
  bit         m_pop;
  bit         m_push;
  logic [1:0] m_code;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        raw1[c] = 1'b0;
        raw2[c] = 1'b0;
        hi_run[c] = 0;
        lo_run[c] = 0;
        armed[c] = 1'b1;
      end
      m_q.delete();
      m_coin = 2'b00;
      m_rej = 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        s_now[c] = raw2[c];
        raw2[c] = raw1[c];
      end
      raw1[0] = bus.nickel_in;
      raw1[1] = bus.dime_in;
      for (int c = 0; c < 2; c++) begin
        req_m[c] = 1'b0;
        if (armed[c]) begin
          if (s_now[c]) begin
            hi_run[c]++;
            if (hi_run[c] == DEB) begin
              req_m[c] = 1'b1;
              armed[c] = 1'b0;
              lo_run[c] = 0;
            end
          end else begin
            hi_run[c] = 0;
          end
        end else begin
          if (!s_now[c]) begin
            lo_run[c]++;
            if (lo_run[c] == DEB) begin
              armed[c] = 1'b1;
              hi_run[c] = 0;
            end
          end else begin
            lo_run[c] = 0;
          end
        end
      end
      m_pop  = (m_q.size() > 0) && !bus.coke && (m_coin == 2'b00);
      m_push = 1'b0;
      m_rej  = 1'b0;
      m_code = req_m[0] ? 2'b01 : 2'b10;
      if (req_m[0] && req_m[1]) begin
        m_rej = 1'b1;
      end else if (req_m[0] || req_m[1]) begin
        if (m_q.size() < 4 || m_pop) m_push = 1'b1;
        else m_rej = 1'b1;
      end
      m_coin = m_pop ? m_q.pop_front() : 2'b00;
      if (m_push) m_q.push_back(m_code);
    end
  end

  always @(negedge clk) begin
    if (model_en) begin
      check("model_coin", int'(bus.coin), int'(m_coin));
      check("model_reject", int'(bus.reject), int'(m_rej));
      check("model_pending", int'(bus.pending), m_q.size());
    end
  end

  // Output monitor: running totals, read as deltas by the directed sequences.
  int         out_n = 0;
  int         out_d = 0;
  int         rej_cnt = 0;
  int         b2b = 0;
  logic [1:0] prev_coin = 2'b00;

  always @(negedge clk) begin
    if (bus.coin == 2'b01) out_n++;
    if (bus.coin == 2'b10) out_d++;
    if (bus.reject) rej_cnt++;
    if (bus.coin != 2'b00 && prev_coin != 2'b00) b2b++;
    prev_coin = bus.coin;
  end

  typedef struct {
    bit   nickel;
    bit   dime;
    bit   coke;
    int   coin;
    bit   reject;
    int   pending;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(bit n, bit d, bit k, int c, bit r, int p);
    vec_t v;
    v.nickel = n; v.dime = d; v.coke = k;
    v.coin = c; v.reject = r; v.pending = p;
    tbl.push_back(v);
  endfunction

  task automatic set_sensor(input int ch, input bit v);
    if (ch == 0) bus.nickel_in = v;
    else bus.dime_in = v;
  endtask

  task automatic pulse(input int ch, input int hi, input int lo);
    set_sensor(ch, 1'b1);
    repeat (hi) @(negedge clk);
    set_sensor(ch, 1'b0);
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_pending(input int n);
    int k;
    k = 0;
    while (int'(bus.pending) != n && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("pending_reach", int'(bus.pending), n);
  endtask

  int n0, d0, r0;

  initial begin
    bus.nickel_in = 1'b0;
    bus.dime_in   = 1'b0;
    bus.coke      = 1'b0;

    // Single nickel: sampled high at edge 1, pushed at edge 6, issued at edge 7.
    for (int i = 1; i <= 16; i++)
      add(i <= 10, 1'b0, 1'b0, (i == 7) ? 1 : 0, 1'b0, (i == 6) ? 1 : 0);
    // Dime high for 3 samples only: glitch, nothing happens.
    for (int i = 1; i <= 11; i++)
      add(1'b0, i <= 3, 1'b0, 0, 1'b0, 0);
    // Nickel and dime confirmed on the same edge: reject, nothing queued.
    for (int i = 1; i <= 12; i++)
      add(i <= 6, i <= 6, 1'b0, 0, (i == 6), 0);

    #12;
    check("reset_coin", int'(bus.coin), 0);
    check("reset_reject", int'(bus.reject), 0);
    check("reset_pending", int'(bus.pending), 0);
    @(negedge clk);
    rst = 1'b1;
    model_en = 1'b1;

    foreach (tbl[i]) begin
      bus.nickel_in = tbl[i].nickel;
      bus.dime_in   = tbl[i].dime;
      bus.coke      = tbl[i].coke;
      @(negedge clk);
      check($sformatf("vec%0d_coin", i), int'(bus.coin), tbl[i].coin);
      check($sformatf("vec%0d_reject", i), int'(bus.reject), int'(tbl[i].reject));
      check($sformatf("vec%0d_pending", i), int'(bus.pending), tbl[i].pending);
    end

    // Bounce: high 6, low 1, high 6, low 10 is a single dime.
    d0 = out_d; r0 = rej_cnt;
    pulse(1, 6, 1);
    pulse(1, 6, 10);
    check("bounce_dimes", out_d - d0, 1);
    check("bounce_rejects", rej_cnt - r0, 0);

    // Back-to-back with dispense: 10,00,10,00,00,01.
    bus.coke = 1'b1;
    pulse(1, 6, 6);
    pulse(1, 6, 6);
    pulse(0, 6, 6);
    wait_pending(3);
    bus.coke = 1'b0;
    @(negedge clk); check("b2b_c0", int'(bus.coin), 2);
    @(negedge clk); check("b2b_c1", int'(bus.coin), 0);
    @(negedge clk); check("b2b_c2", int'(bus.coin), 2);
    @(negedge clk); check("b2b_c3", int'(bus.coin), 0);
    bus.coke = 1'b1;
    @(negedge clk); check("b2b_c4_coke", int'(bus.coin), 0);
    bus.coke = 1'b0;
    @(negedge clk); check("b2b_c5", int'(bus.coin), 1);
    check("b2b_pending", int'(bus.pending), 0);
    repeat (4) @(negedge clk);

    // FIFO full: five nickels under coke, the fifth is rejected.
    bus.coke = 1'b1;
    r0 = rej_cnt;
    repeat (5) pulse(0, 6, 6);
    check("full_pending", int'(bus.pending), 4);
    check("full_rejects", rej_cnt - r0, 1);
    // Sixth nickel pushes on the very edge coke releases and the head pops.
    bus.nickel_in = 1'b1;
    repeat (5) @(negedge clk);
    n0 = out_n;
    bus.coke = 1'b0;
    @(negedge clk);
    bus.nickel_in = 1'b0;
    check("fullpop_reject", int'(bus.reject), 0);
    check("fullpop_pending", int'(bus.pending), 4);
    check("fullpop_coin", int'(bus.coin), 1);
    repeat (20) @(negedge clk);
    check("drain_nickels", out_n - n0, 5);
    check("drain_pending", int'(bus.pending), 0);

    // Reset mid-operation with three coins queued and one on the bus.
    bus.coke = 1'b1;
    pulse(0, 6, 6);
    pulse(1, 6, 6);
    pulse(0, 6, 6);
    wait_pending(3);
    bus.coke = 1'b0;
    @(negedge clk);
    check("prerst_coin", int'(bus.coin), 1);
    check("prerst_pending", int'(bus.pending), 2);
    #2 rst = 1'b0;
    #1;
    check("rst_coin", int'(bus.coin), 0);
    check("rst_pending", int'(bus.pending), 0);
    check("rst_reject", int'(bus.reject), 0);
    @(negedge clk);
    rst = 1'b1;
    n0 = out_n; d0 = out_d;
    repeat (20) @(negedge clk);
    check("postrst_coins", (out_n - n0) + (out_d - d0), 0);

    // Random sensor runs and coke, alternating mostly-idle and mostly-dispensing phases.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) bus.nickel_in = ~bus.nickel_in;
      if ($urandom_range(0, 5) == 0) bus.dime_in = ~bus.dime_in;
      bus.coke = ($urandom_range(0, 9) < ((((i / 200) % 2) == 1) ? 8 : 2));
      @(negedge clk);
    end
    bus.nickel_in = 1'b0;
    bus.dime_in   = 1'b0;
    bus.coke      = 1'b0;
    repeat (20) @(negedge clk);
    check("no_back_to_back", b2b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
